// File: rtl/quat_pkg.sv
// Shared definitions for the quaternion-to-rotation-matrix converter:
// fixed-point defaults, FSM state encoding, product-bank indices and the
// 16-bit saturation helper.
package quat_pkg;

  localparam int FRAC_BITS_DEF = 14;
  localparam logic signed [35:0] ONE_DEF = 36'sd1 <<< (2 * FRAC_BITS_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_COMB = 2'd2
  } state_t;

  // Product bank slots, in the order the multiplier produces them.
  localparam int N_PROD = 9;
  localparam logic [3:0] P11 = 4'd0;
  localparam logic [3:0] P22 = 4'd1;
  localparam logic [3:0] P33 = 4'd2;
  localparam logic [3:0] P01 = 4'd3;
  localparam logic [3:0] P02 = 4'd4;
  localparam logic [3:0] P03 = 4'd5;
  localparam logic [3:0] P12 = 4'd6;
  localparam logic [3:0] P13 = 4'd7;
  localparam logic [3:0] P23 = 4'd8;
  localparam logic [3:0] P_LAST = P23;

  // Matrix element slots, row-major.
  localparam int E00 = 0;
  localparam int E01 = 1;
  localparam int E02 = 2;
  localparam int E10 = 3;
  localparam int E11 = 4;
  localparam int E12 = 5;
  localparam int E20 = 6;
  localparam int E21 = 7;
  localparam int E22 = 8;

  // Clamp a wide signed value into the int16 range.
  function automatic logic signed [15:0] sat16(input logic signed [35:0] v);
    if (v > 36'sd32767) begin
      return 16'sh7fff;
    end else if (v < -36'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/quat_mul_s16.sv
// Single shared signed 16x16 multiplier. The product index selects which
// pair of latched quaternion components is multiplied this cycle.
module quat_mul_s16
  import quat_pkg::*;
(
  input  logic signed [15:0] q0,
  input  logic signed [15:0] q1,
  input  logic signed [15:0] q2,
  input  logic signed [15:0] q3,
  input  logic        [3:0]  idx,
  output logic signed [31:0] prod
);

  logic signed [15:0] a;
  logic signed [15:0] b;

  // Operand select by product index, then a full-width signed multiply.
  always_comb begin
    a = '0;
    b = '0;
    case (idx)
      P11:     begin a = q1; b = q1; end
      P22:     begin a = q2; b = q2; end
      P33:     begin a = q3; b = q3; end
      P01:     begin a = q0; b = q1; end
      P02:     begin a = q0; b = q2; end
      P03:     begin a = q0; b = q3; end
      P12:     begin a = q1; b = q2; end
      P13:     begin a = q1; b = q3; end
      P23:     begin a = q2; b = q3; end
      default: begin a = '0; b = '0; end
    endcase
    // Both operands are sign-extended to 32 bits; the true product always fits.
    prod = 32'(a) * 32'(b);
  end

endmodule

// File: rtl/quat_to_rotm.sv
// Converts a fixed-point quaternion frame into a 3x3 rotation matrix.
// Nine products are formed one per cycle on a shared multiplier, then all
// nine matrix elements are combined, shifted and saturated in one cycle.
// Handshake: in_valid is a one-cycle strobe accepted only in IDLE (no
// back-pressure; frames arriving while busy are counted in drop_cnt and
// discarded); out_valid is a one-cycle pulse marking new r** values.
module quat_to_rotm
  import quat_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] q0,
  input  logic signed [15:0] q1,
  input  logic signed [15:0] q2,
  input  logic signed [15:0] q3,
  input  logic               in_valid,
  output logic signed [15:0] r00,
  output logic signed [15:0] r01,
  output logic signed [15:0] r02,
  output logic signed [15:0] r10,
  output logic signed [15:0] r11,
  output logic signed [15:0] r12,
  output logic signed [15:0] r20,
  output logic signed [15:0] r21,
  output logic signed [15:0] r22,
  output logic               out_valid,
  output logic               busy,
  output logic        [7:0]  drop_cnt
);

  localparam logic signed [35:0] ONE = 36'sd1 <<< (2 * FRAC_BITS);

  state_t             state_q;
  state_t             state_d;
  logic        [3:0]  idx_q;
  logic signed [15:0] qa0, qa1, qa2, qa3;
  logic signed [31:0] prod;
  logic signed [31:0] prod_bank [N_PROD];
  logic signed [35:0] p [N_PROD];
  logic signed [35:0] s [9];
  logic signed [15:0] r_d [9];
  logic signed [15:0] r_q [9];

  quat_mul_s16 u_mul (
    .q0   (qa0),
    .q1   (qa1),
    .q2   (qa2),
    .q3   (qa3),
    .idx  (idx_q),
    .prod (prod)
  );

  // Next-state logic: accept in IDLE, nine multiply steps, one combine step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_MUL;
      ST_MUL:  if (idx_q == P_LAST) state_d = ST_COMB;
      ST_COMB: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Element combine: 36-bit sums, arithmetic shift down (floor), saturate.
  always_comb begin
    for (int i = 0; i < N_PROD; i++) begin
      p[i] = 36'(prod_bank[i]);
    end
    s[E00] = ONE - ((p[P22] + p[P33]) <<< 1);
    s[E11] = ONE - ((p[P11] + p[P33]) <<< 1);
    s[E22] = ONE - ((p[P11] + p[P22]) <<< 1);
    s[E01] = (p[P12] - p[P03]) <<< 1;
    s[E10] = (p[P12] + p[P03]) <<< 1;
    s[E02] = (p[P13] + p[P02]) <<< 1;
    s[E20] = (p[P13] - p[P02]) <<< 1;
    s[E12] = (p[P23] - p[P01]) <<< 1;
    s[E21] = (p[P23] + p[P01]) <<< 1;
    for (int i = 0; i < 9; i++) begin
      r_d[i] = sat16(s[i] >>> FRAC_BITS);
    end
  end

  // Datapath: latch the frame, fill the product bank, publish results, count drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      qa0       <= '0;
      qa1       <= '0;
      qa2       <= '0;
      qa3       <= '0;
      out_valid <= 1'b0;
      drop_cnt  <= '0;
      for (int i = 0; i < N_PROD; i++) prod_bank[i] <= '0;
      for (int i = 0; i < 9; i++) r_q[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            qa0   <= q0;
            qa1   <= q1;
            qa2   <= q2;
            qa3   <= q3;
            idx_q <= '0;
          end
        end
        ST_MUL: begin
          prod_bank[idx_q] <= prod;
          idx_q            <= idx_q + 4'd1;
        end
        ST_COMB: begin
          for (int i = 0; i < 9; i++) r_q[i] <= r_d[i];
          out_valid <= 1'b1;
        end
        default: ;
      endcase
      if (in_valid && (state_q != ST_IDLE) && (drop_cnt != 8'hff)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign r00  = r_q[E00];
  assign r01  = r_q[E01];
  assign r02  = r_q[E02];
  assign r10  = r_q[E10];
  assign r11  = r_q[E11];
  assign r12  = r_q[E12];
  assign r20  = r_q[E20];
  assign r21  = r_q[E21];
  assign r22  = r_q[E22];

endmodule

// File: tb/tb_quat_to_rotm.sv
// Bench for quat_to_rotm: directed quaternion frames with hand-computed
// matrices pushed into an expected queue; a negedge monitor pops and
// compares whenever out_valid is seen.
module tb_quat_to_rotm;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [15:0] q0, q1, q2, q3;
  logic               in_valid;
  logic signed [15:0] r00, r01, r02, r10, r11, r12, r20, r21, r22;
  logic               out_valid;
  logic               busy;
  logic        [7:0]  drop_cnt;

  quat_to_rotm #(.FRAC_BITS(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .q0        (q0),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .in_valid  (in_valid),
    .r00       (r00),
    .r01       (r01),
    .r02       (r02),
    .r10       (r10),
    .r11       (r11),
    .r12       (r12),
    .r20       (r20),
    .r21       (r21),
    .r22       (r22),
    .out_valid (out_valid),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [143:0] exp_q[$];
  int           exp_cyc_q[$];
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [143:0] pack9(input int a, input int b, input int c,
                                         input int d, input int e, input int f,
                                         input int g, input int h, input int i);
    return {16'(a), 16'(b), 16'(c), 16'(d), 16'(e), 16'(f), 16'(g), 16'(h), 16'(i)};
  endfunction

  logic [143:0] cur_r;
  logic [143:0] last_r;
  logic [143:0] mon_e;
  int           mon_c;
  string        names[9] = '{"r00", "r01", "r02", "r10", "r11", "r12", "r20", "r21", "r22"};

  assign cur_r = {r00, r01, r02, r10, r11, r12, r20, r21, r22};

  // Monitor: compare each result against the queue head; outputs must hold otherwise.
  always @(negedge clk) begin
    if (rst) begin
      last_r = '0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("out_cycle", cyc, mon_c);
        for (int i = 0; i < 9; i++) begin
          check(names[i], int'($signed(cur_r[143-16*i -: 16])),
                int'($signed(mon_e[143-16*i -: 16])));
        end
        last_r = mon_e;
      end
    end else begin
      check("r_hold", int'(cur_r != last_r), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    q0 = a; q1 = b; q2 = c; q3 = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_junk();
    pulse(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
          16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] d,
                      input logic [143:0] exp, output int n);
    n = cyc;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(n + 11);
    pulse(a, b, c, d);
  endtask

  task automatic run_vec(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d,
                         input logic [143:0] exp);
    int n;
    send(a, b, c, d, exp, n);
    wait_to(n + 13);
  endtask

  // ---------------- stimulus ----------------
  logic [143:0] ident;
  logic [143:0] rot_z90;
  int n, n2, exp_drop;

  initial begin
    ident   = pack9(16384, 0, 0, 0, 16384, 0, 0, 0, 16384);
    rot_z90 = pack9(0, -16384, 0, 16383, 0, 0, 0, 0, 16384);
    in_valid = 1'b0;
    q0 = '0; q1 = '0; q2 = '0; q3 = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_r_zero", int'(cur_r != '0), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Identity, with the busy window checked cycle by cycle.
    send(16384, 0, 0, 0, ident, n);
    for (int k = n + 1; k <= n + 11; k++) begin
      wait_to(k);
      check("busy_window", int'(busy), int'(k <= n + 10));
    end
    wait_to(n + 13);

    // Directed rotations and edge cases.
    run_vec(11585, 0, 0, 11585, rot_z90);
    run_vec(-11585, 0, 0, 11585, pack9(0, 16383, 0, -16384, 0, 0, 0, 0, 16384));
    run_vec(11585, 11585, 0, 0, pack9(16384, 0, 0, 0, 0, -16384, 0, 16383, 0));
    run_vec(11585, 0, 11585, 0, pack9(0, 0, 16383, 0, 16384, 0, -16384, 0, 0));
    run_vec(0, 16384, 0, 0, pack9(16384, 0, 0, 0, -16384, 0, 0, 0, -16384));
    run_vec(8192, 8192, 8192, 8192, pack9(0, 0, 16384, 16384, 0, 0, 0, 16384, 0));
    run_vec(0, 32767, 32767, 0, pack9(-32768, 32767, 0, 32767, -32768, 0, 0, 0, -32768));

    // Overrun: two drops during one frame, then back-to-back accept at N+11.
    send(16384, 0, 0, 0, ident, n);
    wait_to(n + 3);
    pulse_junk();
    wait_to(n + 5);
    pulse_junk();
    check("drop_cnt_after_two", int'(drop_cnt), 2);
    wait_to(n + 11);
    send(11585, 0, 0, 11585, rot_z90, n2);
    check("n2_is_n_plus_11", n2, n + 11);
    wait_to(n2 + 13);
    check("drop_cnt_overrun", int'(drop_cnt), 2);

    // Saturation: 300 dropped pulses across 30 continuously strobed frames.
    exp_drop = 2;
    for (int f = 0; f < 30; f++) begin
      send(16384, 0, 0, 0, ident, n);
      for (int k = 0; k < 10; k++) pulse_junk();
      exp_drop = (exp_drop + 10 > 255) ? 255 : exp_drop + 10;
      check("drop_cnt_burst", int'(drop_cnt), exp_drop);
    end
    wait_to(n + 13);
    check("drop_cnt_saturated", int'(drop_cnt), 255);

    // Async reset mid-computation: frame discarded, then a clean frame.
    n = cyc;
    pulse(16384, 0, 0, 0);
    wait_to(n + 5);
    #2;
    rst = 1'b1;
    #1;
    check("arst_r_zero", int'(cur_r != '0), 0);
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_drop_cnt", int'(drop_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = cyc; k <= n + 14; k++) begin
      wait_to(k);
      check("arst_no_out_valid", int'(out_valid), 0);
    end
    run_vec(16384, 0, 0, 0, ident);

    wait_to(cyc + 5);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/quat_to_rotm.md
# quat_to_rotm

Converts each four-component int16 quaternion frame from the UART frame receiver into a 3x3 rotation matrix in the same fixed-point format. It sits directly downstream of the receiver: it consumes `q0..q3` with the one-cycle `valid` pulse and presents nine int16 matrix elements with a one-cycle `out_valid` pulse. It uses a single time-shared 16x16 signed multiplier, stepped by an FSM.

## Interface
- `FRAC_BITS`, default 14. Fraction bits of both input and output; 1.0 = 2^FRAC_BITS = 16384.
- `clk` in 1. The single clock; all state updates on its rising edge.
- `rst` in 1. Asynchronous, active-high reset.
- `q0 q1 q2 q3` in 16 each. Signed quaternion (w, x, y, z); sampled only on acceptance.
- `in_valid` in 1. One-cycle frame strobe; connects to the receiver's `valid`.
- `r00 r01 r02 r10 r11 r12 r20 r21 r22` out 16 each. Signed matrix elements, registered; hold their value until the next result.
- `out_valid` out 1. One-cycle pulse when the matrix registers update.
- `busy` out 1. High from the cycle after acceptance through the COMB state.
- `drop_cnt` out 8. Count of frames dropped while busy; saturates at 255.

## Operation
- FSM states: IDLE, MUL, COMB.
- IDLE:
  - On `in_valid`=1, latch `q0..q3`, set idx=0 and go to MUL.
  - Otherwise stay in IDLE.
- MUL: each cycle computes one product and stores it in a 32-bit signed product bank.
  - Product order by idx 0..8: q1q1, q2q2, q3q3, q0q1, q0q2, q0q3, q1q2, q1q3, q2q3.
  - After idx=8, go to COMB.
- COMB: in one cycle, compute all nine elements using 36-bit signed intermediates. ONE = 1<<(2*FRAC_BITS).
  - r00 = ONE-2(p22+p33); r11 = ONE-2(p11+p33); r22 = ONE-2(p11+p22).
  - r01 = 2(p12-p03); r10 = 2(p12+p03).
  - r02 = 2(p13+p02); r20 = 2(p13-p02).
  - r12 = 2(p23-p01); r21 = 2(p23+p01).
  - Each element = sat16(s >>> FRAC_BITS), using an arithmetic shift (floor, no rounding).
  - sat16 clamps to [-32768, 32767].
  - Register all nine elements, pulse `out_valid`, return to IDLE.
- No normalisation of the quaternion is performed; non-unit inputs scale the result and may saturate.
- `in_valid` while state is not IDLE: the frame is dropped, `drop_cnt` increments (saturating at 255), and the in-flight computation is unaffected.
- Reset values: all `rXX`=0, `out_valid`=0, `busy`=0, `drop_cnt`=0, state IDLE, product bank 0.
- Reset asserted mid-computation discards the frame; no `out_valid` is produced for it.

## Timing
- `in_valid` high in cycle N (state IDLE):
  - `busy` is high in cycles N+1..N+10.
  - Products are stored at the edges ending cycles N+1..N+9.
  - COMB occupies cycle N+10.
  - `out_valid` and the new `rXX` values are visible in cycle N+11.
- Latency is 11 cycles. Minimum accept interval is 11 cycles: `in_valid` in cycle N+11 is accepted, because the state is IDLE while `out_valid` is high.
- `rXX` change only in the cycle `out_valid` is high.
- `drop_cnt` updates on the edge ending the cycle in which the drop occurs.
- The receiver delivers at most one frame per 8 UART bytes, so drops indicate an integration fault.

## Structure
- Package `quat_pkg` holds:
  - the `FRAC_BITS` default and the derived ONE;
  - the state enum (IDLE/MUL/COMB);
  - the product-index constants;
  - the `sat16` function.
- Sub-module `quat_mul_s16`: a combinational signed 16x16 to 32-bit multiplier with an operand select driven by idx. The parent registers its result into the product bank.

## Test plan
- Identity: q=(16384,0,0,0) -> r00=r11=r22=16384, all others 0; `out_valid` exactly at N+11.
- 90° about z: q=(11585,0,0,11585) -> r00=0, r11=0, r22=16384, r01=-16384, r10=16383, all others 0.
- 180° about x: q=(0,16384,0,0) -> r00=16384, r11=-16384, r22=-16384, off-diagonal elements 0.
- Saturation: q=(0,32767,32767,0) -> r00=-32768, r01=32767, r10=32767.
- Overrun:
  - `in_valid` at N, N+3 and N+5 -> one result (for frame N) at N+11 and `drop_cnt`=2.
  - A further `in_valid` at N+11 is accepted, with its result at N+22.
  - 300 pulses while busy -> `drop_cnt` holds at 255.
- Async reset: assert `rst` in cycle N+5 -> outputs 0, `busy`=0, no `out_valid`; the next frame after release completes normally in 11 cycles.
